// File: rtl/clock_divider_bank_if.sv
// Bundles the shared control inputs, per-channel configuration and per-channel
// outputs of the clock divider bank.
//
// Handshake: there is no valid/ready pair. enable is a level that is sampled on
// every rising clk edge. load is a single-cycle strobe that is sampled on a
// rising edge. Every output is a registered level that is valid for the whole
// cycle following the edge that produced it.
interface clock_divider_bank_if #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
);
   logic                          enable;
   logic                          load;
   logic [CHANNELS*CNT_WIDTH-1:0] period;
   logic [CHANNELS*CNT_WIDTH-1:0] high_time;
   logic [CHANNELS*CNT_WIDTH-1:0] phase;
   logic [CHANNELS-1:0]           clk_out;
   logic [CHANNELS-1:0]           running;
   logic [CHANNELS-1:0]           period_start;
   // Per-channel FSM state, 2 bits each: 0=IDLE 1=DELAY 2=RUN 3=STOPPING
   logic [2*CHANNELS-1:0]         state_dbg;

   modport master (
      output enable, load, period, high_time, phase,
      input  clk_out, running, period_start, state_dbg
   );

   modport slave (
      input  enable, load, period, high_time, phase,
      output clk_out, running, period_start, state_dbg
   );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers. Each channel produces a
// registered strobe whose period, high time and start delay are counted in
// system clock cycles. Stopping always finishes the current period, so a high
// pulse is never cut short. New timing can be loaded mid-run and takes effect
// at the next period boundary.
module clock_divider_bank #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   clock_divider_bank_if.slave   bus
);

   localparam int W = CNT_WIDTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DELAY    = 2'd1,
      RUN      = 2'd2,
      STOPPING = 2'd3
   } state_t;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t         state_q;
      logic [W-1:0]   cnt_q;
      logic [W-1:0]   p_act_q, h_act_q;
      logic [W-1:0]   p_sh_q, h_sh_q;
      logic           pending_q;
      logic           clk_out_q, running_q, ps_q;

      logic [W-1:0]   p_in, h_in, d_in;
      logic [W-1:0]   p_eff, cnt_d, p_nxt_d, h_nxt_d;
      logic           wrap;

      assign p_in = bus.period[i*W +: W];
      assign h_in = bus.high_time[i*W +: W];
      assign d_in = bus.phase[i*W +: W];

      // Periods below two cycles cannot show both a high and a low phase.
      assign p_eff = (p_act_q < W'(2)) ? W'(2) : p_act_q;
      // >= rather than == keeps the counter bounded even after an odd reload.
      assign wrap  = (cnt_q >= p_eff - W'(1));
      assign cnt_d = cnt_q + W'(1);

      // Timing for the period that starts at a wrap: a load on the same edge
      // wins over an older pending shadow value.
      assign p_nxt_d = bus.load ? p_in : (pending_q ? p_sh_q : p_act_q);
      assign h_nxt_d = bus.load ? h_in : (pending_q ? h_sh_q : h_act_q);

      // Channel FSM; outputs are registered from the next state and count.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_act_q   <= '0;
            h_act_q   <= '0;
            p_sh_q    <= '0;
            h_sh_q    <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            running_q <= 1'b0;
            ps_q      <= 1'b0;
         end else begin
            if (bus.load && state_q != IDLE) begin
               p_sh_q <= p_in;
               h_sh_q <= h_in;
            end
            case (state_q)
               IDLE: begin
                  pending_q <= 1'b0;
                  clk_out_q <= 1'b0;
                  running_q <= 1'b0;
                  ps_q      <= 1'b0;
                  cnt_q     <= '0;
                  if (bus.enable) begin
                     p_act_q <= p_in;
                     h_act_q <= h_in;
                     if (d_in == '0) begin
                        state_q   <= RUN;
                        clk_out_q <= (h_in != '0);
                        running_q <= 1'b1;
                        ps_q      <= 1'b1;
                     end else begin
                        state_q <= DELAY;
                        cnt_q   <= d_in - W'(1);
                     end
                  end
               end
               DELAY: begin
                  clk_out_q <= 1'b0;
                  running_q <= 1'b0;
                  ps_q      <= 1'b0;
                  if (bus.load) pending_q <= 1'b1;
                  if (!bus.enable) begin
                     state_q   <= IDLE;
                     cnt_q     <= '0;
                     pending_q <= 1'b0;
                  end else if (cnt_q == '0) begin
                     state_q   <= RUN;
                     clk_out_q <= (h_act_q != '0);
                     running_q <= 1'b1;
                     ps_q      <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - W'(1);
                  end
               end
               default: begin // RUN or STOPPING
                  if (wrap) begin
                     p_act_q   <= p_nxt_d;
                     h_act_q   <= h_nxt_d;
                     pending_q <= 1'b0;
                     cnt_q     <= '0;
                     if (state_q == STOPPING && !bus.enable) begin
                        state_q   <= IDLE;
                        clk_out_q <= 1'b0;
                        running_q <= 1'b0;
                        ps_q      <= 1'b0;
                     end else begin
                        state_q   <= bus.enable ? RUN : STOPPING;
                        clk_out_q <= (h_nxt_d != '0);
                        running_q <= 1'b1;
                        ps_q      <= 1'b1;
                     end
                  end else begin
                     if (bus.load) pending_q <= 1'b1;
                     state_q   <= bus.enable ? RUN : STOPPING;
                     cnt_q     <= cnt_d;
                     clk_out_q <= (cnt_d < h_act_q);
                     running_q <= 1'b1;
                     ps_q      <= 1'b0;
                  end
               end
            endcase
         end
      end

      assign bus.clk_out[i]          = clk_out_q;
      assign bus.running[i]          = running_q;
      assign bus.period_start[i]     = ps_q;
      assign bus.state_dbg[2*i +: 2] = state_q;
   end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Synthesizable, parametrised successor to the behavioural clock generator.
- Derives CHANNELS independent divided clocks from one system clock, each with its own programmable period, high time (duty) and phase offset, all counted in integer system-clock cycles.
- Shared enable, with glitch-free start and stop per channel.
- Feeds the multi-cycle / multi-phase timing of the processor and testbench timing infrastructure; outputs are registered strobes, not gated clocks.

Parameters:
CHANNELS, 4, number of independent output channels
CNT_WIDTH, 8, width of the period, high-time and phase fields and of each channel counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  level; starts (1) or requests stop (0) for all channels
load  input  1  one-cycle request to capture new period/high_time into shadow registers
period  input  CHANNELS*CNT_WIDTH  per-channel period P in cycles; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
high_time  input  CHANNELS*CNT_WIDTH  per-channel high cycles H per period
phase  input  CHANNELS*CNT_WIDTH  per-channel start delay D in cycles
clk_out  output  CHANNELS  divided clock per channel, registered
running  output  CHANNELS  channel is in RUN or STOPPING
period_start  output  CHANNELS  one-cycle pulse in the first cycle of each period

Behaviour:
- Reset (async, immediate): all channels to IDLE; clk_out=0, running=0, period_start=0; counters, active config and shadow config cleared.
- Per-channel FSM states: IDLE, DELAY, RUN, STOPPING. The counter cnt is CNT_WIDTH bits.
- Effective values:
  - P_eff = max(period, 2).
  - H >= P_eff: clk_out constantly high while in RUN/STOPPING.
  - H = 0: clk_out constantly low, but period_start still pulses.
- IDLE:
  - On an edge sampling enable=1, capture period/high_time/phase into the active registers.
  - D=0: go to RUN with cnt=0.
  - D>0: go to DELAY with cnt=D-1.
- DELAY:
  - cnt decrements each cycle; at cnt=0 go to RUN with cnt=0.
  - enable sampled 0: go straight to IDLE; no pulse is ever emitted.
- Output timing: clk_out is registered from the next state.
  - clk_out = 1 in the cycle after an edge that leaves the channel in RUN/STOPPING with cnt < H_active.
  - With enable sampled at edge k: clk_out first goes high after edge k (D=0) or after edge k+D.
  - Each period is then exactly H cycles high followed by P_eff−H cycles low.
- RUN:
  - cnt increments and wraps from P_eff−1 to 0.
  - period_start=1 for the cycle in which cnt=0.
  - enable sampled 0: go to STOPPING.
- STOPPING:
  - Continue counting; the current period completes in full, so high pulses are never truncated.
  - On the wrap edge (cnt=P_eff−1), go to IDLE with clk_out=0 and no period_start.
  - enable sampled 1 while in STOPPING: return to RUN with no gap or phase change.
- Shadow/load:
  - load sampled 1: latch period/high_time for all channels into the shadow registers and set pending.
  - At a channel's next wrap edge, active ← shadow and that channel's pending is cleared; the new timing takes effect from that cnt=0.
  - load is ignored for channels in IDLE; their config is taken at start instead.
  - phase is never reloaded mid-run; it applies only at the next start from IDLE.
  - load and a wrap on the same edge: the wrap applies the newly loaded value.
- Channels are fully independent apart from the shared enable/load. Channels with equal D and P stay cycle-aligned indefinitely.
- Edge of enable: a change of enable while a channel is IDLE and enable=0 has no effect.

Test Plan:
1. CHANNELS=4, P={4,6,8,10}, H={2,3,1,10}, D=0; enable from cycle 5 → clk_out[0] 1100 repeating from the cycle after the edge; ch1 111000; ch2 10000000; ch3 constant 1; period_start aligned to each rising edge.
2. P=8, H=4, D={0,2,4,6} → four outputs are phase-shifted copies, each lagging the previous by exactly 2 cycles, verified over 10 periods.
3. P=10, H=5, running; drop enable at cnt=2 → high pulse completes (5 cycles), low completes, then IDLE, running=0; re-assert enable at cnt=7 in STOPPING → no gap in the waveform.
4. P=6, H=3; pulse load with P=4, H=1 mid-period → current 6-cycle period finishes unchanged, next period is 1000; pulse load on the wrap edge → new value is used immediately.
5. Assert reset mid-high pulse (async, between edges) → clk_out, running and period_start all 0 without waiting for clk; after release, a restart with D=3 produces the first high 3 cycles after the enable edge.
6. Boundary: period=0 and period=1 behave as P=2; H=0 gives constant low with period_start every 2 cycles; enable dropped during DELAY → no pulse ever appears.
